// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_pkg
//  Description : Shared types and constants for the parametrised SRAM
//                controller: FSM state encoding, supported read-latency
//                bounds, latency counter width and a byte-lane helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_pkg;

  // Supported read-latency range; the counter is sized for the maximum.
  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 4;
  localparam int CNT_W        = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR      = 2'd2,
    RESP    = 2'd3
  } state_e;

  // Number of byte lanes in a data word.
  function automatic int byte_count(input int data_w);
    return data_w / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_array.sv
`default_nettype none
// ============================================================================
//  Module      : sram_array
//  Description : Word-addressed storage with a byte-enabled write port and a
//                registered read port. Contents are never reset.
//                With SRAM_PARITY_EN defined, one even-parity bit per byte is
//                stored alongside the data and checked on every read.
//  Ports       : clk_i            - rising-edge clock
//                we_i/waddr_i     - write strobe and word address
//                wdata_i/be_i     - write data and per-byte enables
//                par_flip_i       - (SRAM_PARITY_EN) invert stored parity
//                re_i/raddr_i     - read strobe and word address
//                rdata_o          - registered read data
//                par_err_o        - (SRAM_PARITY_EN) registered parity error
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_array
  import sram_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   waddr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] be_i,
`ifdef SRAM_PARITY_EN
  input  logic                par_flip_i,
  output logic                par_err_o,
`endif
  input  logic                re_i,
  input  logic [ADDR_W-1:0]   raddr_i,
  output logic [DATA_W-1:0]   rdata_o
);

  localparam int NB = byte_count(DATA_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

`ifdef SRAM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic          par_mis_d;
  logic          par_err_q;

  // Even parity: the stored bit equals the XOR of the byte, so a clean
  // byte plus its parity bit always XORs to zero.
  always_comb begin
    par_mis_d = 1'b0;
    for (int b = 0; b < NB; b++) begin
      par_mis_d = par_mis_d | ((^mem_q[raddr_i][8*b +: 8]) ^ par_q[raddr_i][b]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (be_i[b]) par_q[waddr_i][b] <= (^wdata_i[8*b +: 8]) ^ par_flip_i;
      end
    end
    if (re_i) par_err_q <= par_mis_d;
  end

  assign par_err_o = par_err_q;
`endif

endmodule
`default_nettype wire

// File: rtl/sram_ctrl_param.sv
`default_nettype none
// ============================================================================
//  Module      : sram_ctrl_param
//  Description : Single-outstanding SRAM controller. Accepts a read or write
//                qualified by addr_ready_i, completes with a one-cycle
//                f_ready_o pulse and flags illegal/out-of-range requests.
//                Optional feature macro: SRAM_PARITY_EN (per-byte parity,
//                adds parity_inject_i and reports parity errors on reads).
//  Ports       : clk_i, reset_i (async, active-high)
//                addr_i, addr_ready_i, read_pulse_i, write_pulse_i,
//                byte_en_i, datain_i           - request
//                dataout_o, f_ready_o, busy_o, err_o - response/status
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_ctrl_param
  import sram_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic                addr_ready_i,
  input  logic                read_pulse_i,
  input  logic                write_pulse_i,
  input  logic [DATA_W/8-1:0] byte_en_i,
  input  logic [DATA_W-1:0]   datain_i,
`ifdef SRAM_PARITY_EN
  input  logic                parity_inject_i,
`endif
  output logic [DATA_W-1:0]   dataout_o,
  output logic                f_ready_o,
  output logic                busy_o,
  output logic                err_o
);

  localparam int NB = byte_count(DATA_W);
  // Out-of-range latencies are clamped into the supported window.
  localparam int LAT_EFF = (READ_LAT < READ_LAT_MIN) ? READ_LAT_MIN :
                           (READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT;
  localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(LAT_EFF - 1);
  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]  C_DEPTH = (ADDR_W+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NB-1:0]     be_q, be_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] dataout_q, dataout_d;
  logic              err_q, err_d;

  logic              can_accept;
  logic              req;
  logic              illegal;
  logic              rd_accept;
  logic [DATA_W-1:0] rd_data;
  logic              rd_par_err;

`ifdef SRAM_PARITY_EN
  logic              inj_q, inj_d;
`else
  assign rd_par_err = 1'b0;
`endif

  // RESP is a completion cycle only, so it accepts like IDLE to allow
  // back-to-back requests.
  assign can_accept = (state_q == IDLE) || (state_q == RESP);
  assign req        = addr_ready_i & (read_pulse_i | write_pulse_i);
  assign illegal    = (read_pulse_i & write_pulse_i) | ({1'b0, addr_i} >= C_DEPTH);
  // The array read is launched on the acceptance edge; its registered
  // output stays stable until RD_WAIT hands it to dataout.
  assign rd_accept  = can_accept & req & ~illegal & read_pulse_i;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    cnt_d     = cnt_q;
    dataout_d = dataout_q;
    err_d     = 1'b0;
`ifdef SRAM_PARITY_EN
    inj_d     = inj_q;
`endif
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (req) begin
          if (illegal) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else if (read_pulse_i) begin
            state_d = RD_WAIT;
            cnt_d   = '0;
          end else begin
            state_d = WR;
            addr_d  = addr_i;
            wdata_d = datain_i;
            be_d    = byte_en_i;
`ifdef SRAM_PARITY_EN
            inj_d   = parity_inject_i;
`endif
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == C_LAST) begin
          state_d   = RESP;
          dataout_d = rd_data;
          err_d     = rd_par_err;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WR:      state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      cnt_q     <= '0;
      dataout_q <= '0;
      err_q     <= 1'b0;
`ifdef SRAM_PARITY_EN
      inj_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      cnt_q     <= cnt_d;
      dataout_q <= dataout_d;
      err_q     <= err_d;
`ifdef SRAM_PARITY_EN
      inj_q     <= inj_d;
`endif
    end
  end

  // Writes commit on the edge leaving WR, so an async reset while in WR
  // removes the strobe before the commit edge.
  sram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk_i      (clk_i),
    .we_i       (state_q == WR),
    .waddr_i    (addr_q),
    .wdata_i    (wdata_q),
    .be_i       (be_q),
`ifdef SRAM_PARITY_EN
    .par_flip_i (inj_q),
    .par_err_o  (rd_par_err),
`endif
    .re_i       (rd_accept),
    .raddr_i    (addr_i),
    .rdata_o    (rd_data)
  );

  assign dataout_o = dataout_q;
  assign f_ready_o = (state_q == RESP);
  assign busy_o    = (state_q != IDLE);
  assign err_o     = err_q;

endmodule
`default_nettype wire

// File: doc/sram_ctrl_param.md
Name: sram_ctrl_param

Overview:
- Parametrised, clocked successor to the pulse-driven SRAM model used by the core's memory path.
- Accepts one read or write request at a time, qualified by addr_ready plus read_pulse or write_pulse.
- Supports byte-granular writes and a configurable read latency.
- Signals completion with a one-cycle f_ready pulse; flags illegal and out-of-range requests.
- Sits between the load/store unit and the data memory array.

Parameters:
- ADDR_W, 10, word-address width.
- DATA_W, 32, data width in bits; must be a multiple of 8.
- DEPTH, 1024, number of words; DEPTH <= 2**ADDR_W.
- READ_LAT, 1, cycles from request acceptance to read data valid; legal range 1..4.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- addr  in  ADDR_W  word address; sampled on acceptance.
- addr_ready  in  1  address/request-valid qualifier.
- read_pulse  in  1  read request strobe.
- write_pulse  in  1  write request strobe.
- byte_en  in  DATA_W/8  per-byte write enable; ignored on reads.
- datain  in  DATA_W  write data; sampled on acceptance.
- dataout  out  DATA_W  read data; holds the last read value.
- f_ready  out  1  one-cycle completion pulse.
- busy  out  1  high while a request is in flight.
- err  out  1  error flag, valid only with f_ready.

Behaviour:
- Reset (async, reset=1):
  - dataout=0, f_ready=0, busy=0, err=0; state=IDLE.
  - Array contents are not cleared.
  - Reset asserted mid-operation aborts the request. A write aborted before its commit edge leaves memory unchanged.
- Acceptance: on a rising edge in IDLE with addr_ready=1 and (read_pulse XOR write_pulse)=1. Request inputs are ignored while busy=1 (no queuing).
- States:
  - IDLE: on an accepted read, go to RD_WAIT; on an accepted write, go to WR.
    - addr_ready=1 with both pulses high, or addr >= DEPTH: go to RESP with err=1 and no array access.
  - RD_WAIT: counter counts READ_LAT-1 additional cycles, then go to RESP.
  - WR: commits the bytes with byte_en[i]=1 on this edge; go to RESP. byte_en=0 is a legal no-op write.
  - RESP: f_ready=1 for exactly one cycle; next state is IDLE. On reads, dataout is updated on the same edge f_ready rises.
- busy=1 from the edge after acceptance until the edge that returns to IDLE (f_ready cycle included).
- Latency from the acceptance edge to f_ready high:
  - read: READ_LAT+1 cycles.
  - write: 2 cycles.
  - error: 1 cycle.
- Back-to-back: a new request may be accepted on the edge that leaves RESP (IDLE-equivalent).
- A read after a write to the same address returns the new data.
- Errored requests leave dataout unchanged.
- addr = DEPTH-1 is legal; addr = DEPTH is an error.
- Pulses with addr_ready=0 are ignored.

Optional Feature:
- Macro: SRAM_PARITY_EN.
- Defined:
  - Store one even-parity bit per byte, written with the byte.
  - On read, recompute parity. On mismatch, set err=1 with f_ready and still drive the read data.
  - A hidden debug input, parity_inject (1 bit), flips the stored parity on writes; used only by the bench.
- Undefined: no parity storage; err reports only illegal/out-of-range requests; parity_inject port absent.

Decomposition:
- Package sram_pkg: state enum (IDLE, RD_WAIT, WR, RESP), READ_LAT bounds constants, byte-count helper function.
- One sub-module, sram_array: the storage array with byte-enabled write port and registered read port; parity bits live here when SRAM_PARITY_EN is defined.
- FSM, latency counter and error logic stay in the top module.

Test Plan:
- Reset mid-read: READ_LAT=3, read accepted, reset asserted 1 cycle later -> all outputs 0 immediately; no f_ready after release.
- Byte write/readback: write 0xAABBCCDD to addr 5 with byte_en=4'hF, then write 0x11223344 with byte_en=4'b0101, then read addr 5 -> dataout=0xAA22CC44, err=0, f_ready 2 cycles after read acceptance (READ_LAT=1).
- Latency sweep: READ_LAT in {1,2,4} -> f_ready exactly READ_LAT+1 cycles after acceptance; busy high throughout.
- Errors:
  - Both pulses high at addr 0 -> f_ready+err the next cycle, memory unchanged.
  - addr=DEPTH -> err=1.
  - addr=DEPTH-1 -> err=0.
- Busy-drop: issue a second read pulse while busy -> ignored; exactly one f_ready; dataout holds the first result.
- SRAM_PARITY_EN: write with parity_inject=1, then read -> err=1 and data correct; clean write/read -> err=0.
